// File: rtl/instr_fetch_mem_pkg.sv
// Shared definitions for the instruction fetch memory: bubble word, debug FSM
// states and the layout of the debug response word.
package imem_pkg;

   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {
      DBG_IDLE   = 2'd0,
      DBG_ACCESS = 2'd1,
      DBG_RESP   = 2'd2
   } dbg_state_e;

   // Response word layout is {flag, addr, word}, word in the low bits.
   localparam int RSP_FLAG_W   = 1;
   localparam int RSP_WORD_LSB = 0;

   function automatic int rsp_addr_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int rsp_flag_bit(input int data_w, input int addr_w);
      return data_w + addr_w;
   endfunction

   function automatic int rsp_width(input int data_w, input int addr_w);
      return data_w + addr_w + RSP_FLAG_W;
   endfunction

endpackage

// File: rtl/instr_fetch_mem_if.sv
// Fetch and debug bus of the instruction memory; slave = memory side,
// master = CPU/debugger side.
interface instr_fetch_mem_if
   import imem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DBG_ADDR_W = 9
);
   localparam int STRB_W = DATA_W / 8;
   localparam int RSP_W  = rsp_width(DATA_W, DBG_ADDR_W);

   logic [31:0]           pc;
   logic                  fetch_en;
   logic                  stall;
   logic                  flush;
   logic [DATA_W-1:0]     instr;
   logic                  instr_valid;
   logic                  dbg_req_valid;
   logic                  dbg_req_ready;
   logic                  dbg_we;
   logic [DBG_ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0]     dbg_wdata;
   logic [STRB_W-1:0]     dbg_wstrb;
   logic                  dbg_rsp_valid;
   logic                  dbg_rsp_ready;
   logic [RSP_W-1:0]      dbg_rsp_data;
   logic                  dbg_rsp_err;
   logic                  parity_err;

   modport slave (
      input  pc, fetch_en, stall, flush,
      input  dbg_req_valid, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb, dbg_rsp_ready,
      output instr, instr_valid, dbg_req_ready, dbg_rsp_valid, dbg_rsp_data,
      output dbg_rsp_err, parity_err
   );

   modport master (
      output pc, fetch_en, stall, flush,
      output dbg_req_valid, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb, dbg_rsp_ready,
      input  instr, instr_valid, dbg_req_ready, dbg_rsp_valid, dbg_rsp_data,
      input  dbg_rsp_err, parity_err
   );

endinterface

// File: rtl/instr_fetch_mem_dbg_fsm.sv
// Debug access sequencer: IDLE -> ACCESS (one cycle, read or byte-merged write)
// -> RESP (held until the response is taken).
module imem_dbg_fsm
   import imem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DBG_ADDR_W = 9,
   parameter int ADDR_BITS  = 8,
   localparam int STRB_W    = DATA_W / 8,
   localparam int RSP_W     = rsp_width(DATA_W, DBG_ADDR_W)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_en_i,
   input  logic                  req_valid_i,
   input  logic                  we_i,
   input  logic [DBG_ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [STRB_W-1:0]     wstrb_i,
   input  logic                  rsp_ready_i,
   input  logic [DATA_W-1:0]     rd_word_i,
   output logic                  req_ready_o,
   output logic                  rsp_valid_o,
   output logic [RSP_W-1:0]      rsp_data_o,
   output logic                  rsp_err_o,
   output logic                  mem_we_o,
   output logic [ADDR_BITS-1:0]  mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o
);
   localparam int ADDR_LSB = rsp_addr_lsb(DATA_W);
   localparam int FLAG_BIT = rsp_flag_bit(DATA_W, DBG_ADDR_W);

   dbg_state_e            state_q, state_d;
   logic                  we_q;
   logic [DBG_ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [STRB_W-1:0]     wstrb_q;
   logic [RSP_W-1:0]      rsp_data_q;
   logic                  rsp_err_q;
   logic                  accept_s;
   logic                  in_range_s;
   logic                  mem_we_s;
   logic [DATA_W-1:0]     merged_s;
   logic [DATA_W-1:0]     rsp_word_s;
   logic [RSP_W-1:0]      rsp_pack_s;

   // Any set bit above the array index means the address is past the end.
   assign in_range_s  = ((addr_q >> ADDR_BITS) == '0);
   assign req_ready_o = (state_q == DBG_IDLE) && !fetch_en_i;
   assign accept_s    = req_valid_i && req_ready_o;

   // Byte merge of the captured write data over the current word.
   always_comb begin
      merged_s = rd_word_i;
      for (int b = 0; b < STRB_W; b++) begin
         if (wstrb_q[b]) begin
            merged_s[8*b +: 8] = wdata_q[8*b +: 8];
         end else begin
            merged_s[8*b +: 8] = rd_word_i[8*b +: 8];
         end
      end
   end

   // Response word and packed response.
   always_comb begin
      if (!in_range_s) begin
         rsp_word_s = '0;
      end else if (we_q) begin
         rsp_word_s = merged_s;
      end else begin
         rsp_word_s = rd_word_i;
      end
      rsp_pack_s                             = '0;
      rsp_pack_s[RSP_WORD_LSB +: DATA_W]     = rsp_word_s;
      rsp_pack_s[ADDR_LSB +: DBG_ADDR_W]     = addr_q;
      rsp_pack_s[FLAG_BIT]                   = 1'b1;
   end

   // Next-state and memory write strobe.
   always_comb begin
      state_d  = state_q;
      mem_we_s = 1'b0;
      case (state_q)
         DBG_IDLE: begin
            if (accept_s) begin
               state_d = DBG_ACCESS;
            end else begin
               state_d = DBG_IDLE;
            end
         end
         DBG_ACCESS: begin
            mem_we_s = we_q && in_range_s;
            state_d  = DBG_RESP;
         end
         DBG_RESP: begin
            if (rsp_ready_i) begin
               state_d = DBG_IDLE;
            end else begin
               state_d = DBG_RESP;
            end
         end
         default: begin
            state_d = DBG_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= DBG_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request capture on acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else if (accept_s) begin
         we_q    <= we_i;
         addr_q  <= addr_i;
         wdata_q <= wdata_i;
         wstrb_q <= wstrb_i;
      end
   end

   // Response registers, loaded at the end of ACCESS and stable through RESP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else if (state_q == DBG_ACCESS) begin
         rsp_data_q <= rsp_pack_s;
         rsp_err_q  <= !in_range_s;
      end
   end

   assign rsp_valid_o = (state_q == DBG_RESP);
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;
   assign mem_we_o    = mem_we_s;
   assign mem_addr_o  = addr_q[ADDR_BITS-1:0];
   assign mem_wdata_o = merged_s;

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory with registered fetch port and a halted-CPU debug port.
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module instr_fetch_mem
   import imem_pkg::*;
#(
   parameter int               DEPTH      = 256,
   parameter int               DATA_W     = 32,
   parameter int               DBG_ADDR_W = 9,
   parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_WORD_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset,
   instr_fetch_mem_if.slave  bus
);
   localparam int ADDR_BITS = $clog2(DEPTH);

   logic [DATA_W-1:0]    mem_q [DEPTH] = '{default: NOP_WORD};
   logic [DATA_W-1:0]    instr_q;
   logic                 instr_valid_q;
   logic [ADDR_BITS-1:0] fetch_idx_s;
   logic [DATA_W-1:0]    fetch_word_s;
   logic                 mem_we_s;
   logic [ADDR_BITS-1:0] mem_addr_s;
   logic [DATA_W-1:0]    mem_wdata_s;
   logic                 unused_pc_s;

   assign fetch_idx_s = bus.pc[ADDR_BITS+1:2];
   assign unused_pc_s = ^{bus.pc[31:ADDR_BITS+2], bus.pc[1:0]};

`ifdef IMEM_PARITY_EN
   logic par_q [DEPTH] = '{default: ^NOP_WORD};
   logic parity_err_q;
   logic par_bad_s;

   assign par_bad_s    = ((^mem_q[fetch_idx_s]) != par_q[fetch_idx_s]);
   assign fetch_word_s = par_bad_s ? NOP_WORD : mem_q[fetch_idx_s];

   // Parity bit tracks every debug write.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         par_q[mem_addr_s] <= ^mem_wdata_s;
      end
   end

   // Sticky parity error, only raised by an actual fetch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_err_q <= 1'b0;
      end else if (!bus.flush && !bus.stall && bus.fetch_en && par_bad_s) begin
         parity_err_q <= 1'b1;
      end
   end

   assign bus.parity_err = parity_err_q;
`else
   assign fetch_word_s   = mem_q[fetch_idx_s];
   assign bus.parity_err = 1'b0;
`endif

   // Array write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_addr_s] <= mem_wdata_s;
      end
   end

   // Fetch pipeline register: flush beats stall beats fetch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q       <= NOP_WORD;
         instr_valid_q <= 1'b0;
      end else if (bus.flush) begin
         instr_q       <= NOP_WORD;
         instr_valid_q <= 1'b0;
      end else if (bus.stall) begin
         instr_q       <= instr_q;
         instr_valid_q <= instr_valid_q;
      end else if (bus.fetch_en) begin
         instr_q       <= fetch_word_s;
         instr_valid_q <= 1'b1;
      end else begin
         instr_valid_q <= 1'b0;
      end
   end

   assign bus.instr       = instr_q;
   assign bus.instr_valid = instr_valid_q;

   imem_dbg_fsm #(
      .DATA_W     (DATA_W),
      .DBG_ADDR_W (DBG_ADDR_W),
      .ADDR_BITS  (ADDR_BITS)
   ) u_dbg_fsm (
      .clk         (clk),
      .reset       (reset),
      .fetch_en_i  (bus.fetch_en),
      .req_valid_i (bus.dbg_req_valid),
      .we_i        (bus.dbg_we),
      .addr_i      (bus.dbg_addr),
      .wdata_i     (bus.dbg_wdata),
      .wstrb_i     (bus.dbg_wstrb),
      .rsp_ready_i (bus.dbg_rsp_ready),
      .rd_word_i   (mem_q[mem_addr_s]),
      .req_ready_o (bus.dbg_req_ready),
      .rsp_valid_o (bus.dbg_rsp_valid),
      .rsp_data_o  (bus.dbg_rsp_data),
      .rsp_err_o   (bus.dbg_rsp_err),
      .mem_we_o    (mem_we_s),
      .mem_addr_o  (mem_addr_s),
      .mem_wdata_o (mem_wdata_s)
   );

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  DEPTH  256  instruction words; power of two, >=2; ADDR_BITS = log2(DEPTH)
  DATA_W  32  instruction word width; multiple of 8
  DBG_ADDR_W  9  debug word-address width; >= ADDR_BITS
  NOP_WORD  32'h00000013  bubble and initialisation word
REQ-002 Ports SHALL be (name direction width meaning):
  clk  in  1  clock
  reset  in  1  asynchronous, active-high reset
  pc  in  32  fetch byte address
  fetch_en  in  1  CPU running; low = halted, debug access allowed
  stall  in  1  hold fetch output
  flush  in  1  branch taken; squash fetch
  instr  out  DATA_W  fetched instruction
  instr_valid  out  1  instr holds a real fetch
  dbg_req_valid / dbg_req_ready  in / out  1  debug request handshake
  dbg_we  in  1  1 = write, 0 = read
  dbg_addr  in  DBG_ADDR_W  debug word address
  dbg_wdata  in  DATA_W  write data
  dbg_wstrb  in  DATA_W/8  byte write enables
  dbg_rsp_valid / dbg_rsp_ready  out / in  1  debug response handshake
  dbg_rsp_data  out  DATA_W+DBG_ADDR_W+1  {1'b1, addr, word}
  dbg_rsp_err  out  1  address out of range
  parity_err  out  1  sticky fetch parity error

Function
REQ-003 Fetch SHALL be registered with 1-cycle latency; index = pc[ADDR_BITS+1:2]; other pc bits ignored.
REQ-004 Per posedge, fetch SHALL apply this priority: flush -> instr=NOP_WORD, valid=0; else stall -> hold both; else fetch_en -> instr=mem[index], valid=1; else valid=0, instr held.
REQ-005 Debug FSM SHALL have states IDLE, ACCESS, RESP; dbg_req_ready=1 only in IDLE with fetch_en=0.
REQ-006 A request accepted (valid&ready) SHALL capture we/addr/wdata/wstrb and go IDLE->ACCESS.
REQ-007 ACCESS SHALL last one cycle: write merges only strobed bytes; read samples mem[addr]; then ->RESP.
REQ-008 dbg_addr >= DEPTH SHALL perform no write, return word 0, set dbg_rsp_err=1.
REQ-009 RESP SHALL assert dbg_rsp_valid with data/err stable until dbg_rsp_ready; then ->IDLE, valid drops same edge.
REQ-010 Write responses SHALL return the post-merge word.
REQ-011 fetch_en rising during ACCESS/RESP SHALL NOT abort the transaction; it completes normally.
REQ-012 Fetch and debug write to the same word on one edge SHALL give fetch the old word.
REQ-013 Memory SHALL initialise to NOP_WORD at elaboration.

Reset
REQ-014 reset SHALL force instr=NOP_WORD, instr_valid=0, FSM=IDLE, dbg_rsp_valid=0, dbg_rsp_data=0, dbg_rsp_err=0, parity_err=0; memory contents unchanged.
REQ-015 reset mid-transaction SHALL drop it with no response; a write already past ACCESS stays written.

Configuration
REQ-016 With IMEM_PARITY_EN defined: each word stores an even-parity bit, updated on debug write; fetch mismatch sets parity_err (sticky until reset) and delivers NOP_WORD with valid=1.
REQ-017 Without IMEM_PARITY_EN: no parity storage; parity_err tied 0.

Structure
REQ-018 Package imem_pkg SHALL hold NOP_WORD default, the debug state enum, and response field widths/offsets.
REQ-019 The debug FSM SHALL be sub-module imem_dbg_fsm; array and fetch path stay in the top.

Verification
REQ-020 Reset, fetch_en=1, pc=0x8 -> next cycle instr=mem[2], valid=1; pc=0x40C -> mem[3] (wrap).
REQ-021 flush=1 with stall=1 -> instr=0x00000013, valid=0 next cycle.
REQ-022 fetch_en=0; write addr 5, data 0xAABBCCDD, wstrb 0b0101 over 0x00000013 -> rsp data {1,5,0x00BB00DD}, err=0.
REQ-023 Read addr 300 (DEPTH 256), rsp_ready low 4 cycles -> rsp_valid held, word 0, err=1, stable throughout.
REQ-024 fetch_en=1 with dbg_req_valid=1 -> req_ready=0, no access; reset during RESP -> rsp_valid=0, FSM IDLE.
REQ-025 IMEM_PARITY_EN: force parity bit of word 7, fetch pc=0x1C -> instr=NOP_WORD, parity_err=1 until reset.
